alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Decodes one MIPS instruction at a time, issues the ALU control
//             (alu_op, alu_shamt, rs_addr, rt_addr) for exactly one cycle,
//             captures the ALU result and presents the completed operation
//             with a valid/ready handshake. The companion ALU evaluates on
//             the falling edge of clock, so its result is settled by the
//             rising edge that ends ISSUE.
//  Ports    : clock, reset               - clock / synchronous active-high reset
//             instr_valid, instr,
//             instr_ready                - instruction input handshake
//             alu_op, alu_shamt,
//             rs_addr, rt_addr           - registered ALU / register-file control
//             alu_result, alu_zero       - ALU feedback
//             out_valid, out_ready,
//             out_result, out_dest,
//             out_wen, out_branch        - completed-operation handshake
//             illegal                    - unsupported encoding flag
//                                          (only with ALU_SEQ_TRAP_EN)
//  Options  : `define ALU_SEQ_TRAP_EN adds the illegal output.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [3:0]  alu_op,
    output logic [4:0]  alu_shamt,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_dest,
    output logic        out_wen,
    output logic        out_branch
`ifdef ALU_SEQ_TRAP_EN
    ,
    output logic        illegal
`endif
);

    // ALUOp encodings
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_ADDU = 4'b1010;
    localparam logic [3:0] OP_SUBU = 4'b1011;
    localparam logic [3:0] OP_BGTZ = 4'b1100;
    localparam logic [3:0] OP_BGEZ = 4'b1101;
    localparam logic [3:0] OP_BNE  = 4'b1110;
    localparam logic [3:0] OP_LUI  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // How the captured ALU result resolves a branch
    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,   // taken when result is zero
        BR_NE   = 2'd2,   // taken when result is non-zero
        BR_ZF   = 2'd3    // taken when the ALU zero flag is set
    } br_kind_t;

    state_t     r_state;
    logic [4:0] r_dest;
    logic       r_wen;
    br_kind_t   r_br;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic [3:0] w_op;
    logic       w_wen;
    logic [4:0] w_dest;
    br_kind_t   w_br;
    logic       w_accept;
    logic       w_taken;

    assign w_opcode = instr[31:26];
    assign w_funct  = instr[5:0];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];

    // A new instruction can be taken while idle, or while the completed
    // operation is being handed off in the same cycle.
    assign instr_ready = (r_state == ST_IDLE) ||
                         ((r_state == ST_DONE) && out_ready);
    assign w_accept    = instr_valid && instr_ready;

    // Instruction decode. Every supported encoding maps to a non-zero
    // ALUOp, so OP_NOP doubles as the "unsupported" marker.
    always_comb begin
        w_op   = OP_NOP;
        w_wen  = 1'b0;
        w_dest = 5'd0;
        w_br   = BR_NONE;
        case (w_opcode)
            6'h00: begin
                case (w_funct)
                    6'h20:   w_op = OP_ADD;
                    6'h21:   w_op = OP_ADDU;
                    6'h22:   w_op = OP_SUB;
                    6'h23:   w_op = OP_SUBU;
                    6'h24:   w_op = OP_AND;
                    6'h25:   w_op = OP_OR;
                    6'h27:   w_op = OP_NOR;
                    6'h2A:   w_op = OP_SLT;
                    6'h00:   w_op = OP_SLL;
                    6'h02:   w_op = OP_SRL;
                    6'h03:   w_op = OP_SRA;
                    default: w_op = OP_NOP;
                endcase
                if (w_op != OP_NOP) begin
                    w_wen  = 1'b1;
                    w_dest = w_rd;
                end
            end
            6'h0F: begin
                w_op   = OP_LUI;
                w_wen  = 1'b1;
                w_dest = w_rt;
            end
            6'h04: begin
                w_op = OP_SUB;    // BEQ compares via subtraction
                w_br = BR_EQ;
            end
            6'h05: begin
                w_op = OP_BNE;
                w_br = BR_NE;
            end
            6'h07: begin
                w_op = OP_BGTZ;
                w_br = BR_ZF;
            end
            6'h01: begin
                if (w_rt == 5'd1) begin
                    w_op = OP_BGEZ;
                    w_br = BR_ZF;
                end
            end
            default: begin
                w_op = OP_NOP;
            end
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_br)
            BR_EQ:   w_taken = (alu_result == 32'd0);
            BR_NE:   w_taken = (alu_result != 32'd0);
            BR_ZF:   w_taken = alu_zero;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_dest     <= 5'd0;
            r_wen      <= 1'b0;
            r_br       <= BR_NONE;
            alu_op     <= OP_NOP;
            alu_shamt  <= 5'd0;
            rs_addr    <= 5'd0;
            rt_addr    <= 5'd0;
            out_valid  <= 1'b0;
            out_result <= 32'd0;
            out_dest   <= 5'd0;
            out_wen    <= 1'b0;
            out_branch <= 1'b0;
`ifdef ALU_SEQ_TRAP_EN
            illegal    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_ISSUE: begin
                    out_result <= alu_result;
                    out_valid  <= 1'b1;
                    out_dest   <= r_dest;
                    out_wen    <= r_wen;
                    out_branch <= w_taken;
                    alu_op     <= OP_NOP;
`ifdef ALU_SEQ_TRAP_EN
                    illegal    <= (alu_op == OP_NOP);
`endif
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef ALU_SEQ_TRAP_EN
                        illegal   <= 1'b0;
`endif
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Acceptance only occurs in IDLE or DONE; it overrides the
            // next-state chosen above and loads the decoded instruction.
            if (w_accept) begin
                alu_op    <= w_op;
                alu_shamt <= instr[10:6];
                rs_addr   <= instr[25:21];
                rt_addr   <= instr[20:16];
                r_dest    <= w_dest;
                r_wen     <= w_wen;
                r_br      <= w_br;
                r_state   <= ST_ISSUE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Purpose  : Directed self-checking bench for alu_sequencer. Inputs change
//             and outputs are sampled 1 ns after each rising clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_wen;
    logic        out_branch;
`ifdef ALU_SEQ_TRAP_EN
    logic        illegal;
`endif

    int vectors;
    int miscompares;

    alu_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_op      (alu_op),
        .alu_shamt   (alu_shamt),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_dest    (out_dest),
        .out_wen     (out_wen),
        .out_branch  (out_branch)
`ifdef ALU_SEQ_TRAP_EN
        ,
        .illegal     (illegal)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present an instruction and let it be accepted on the next edge.
    task automatic accept(input logic [31:0] word);
        instr_valid = 1'b1;
        instr       = word;
        step();
        instr_valid = 1'b0;
    endtask

    // Hand the completed operation to the consumer and return to IDLE.
    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0 || alu_op !== 4'b0000 || out_result !== 32'd0 ||
            out_dest !== 5'd0 || out_wen !== 1'b0 || out_branch !== 1'b0 ||
            alu_shamt !== 5'd0 || rs_addr !== 5'd0 || rt_addr !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b op=%h res=%h dest=%0d wen=%b br=%b, required all zero",
                     out_valid, alu_op, out_result, out_dest, out_wen, out_branch);
        end
`ifdef ALU_SEQ_TRAP_EN
        vectors++;
        if (illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_illegal: got %b required 0", illegal);
        end
`endif
        reset = 1'b0;
        step();
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b required 1", instr_ready);
        end
    endtask

    task automatic test_add();
        accept(32'h012A4020);
        vectors++;
        if (alu_op !== 4'b0001 || rs_addr !== 5'd9 || rt_addr !== 5'd10 ||
            out_valid !== 1'b0 || instr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL add_issue: got op=%b rs=%0d rt=%0d valid=%b ready=%b, required 0001 9 10 0 0",
                     alu_op, rs_addr, rt_addr, out_valid, instr_ready);
        end
        alu_result = 32'd7;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'd7 || out_dest !== 5'd8 ||
            out_wen !== 1'b1 || out_branch !== 1'b0 || alu_op !== 4'b0000) begin
            miscompares++;
            $display("FAIL add_done: got valid=%b res=%h dest=%0d wen=%b br=%b op=%b, required 1 7 8 1 0 0000",
                     out_valid, out_result, out_dest, out_wen, out_branch, alu_op);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL add_done_ready: got %b required 1", instr_ready);
        end
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || instr_ready !== 1'b1 || alu_op !== 4'b0000) begin
            miscompares++;
            $display("FAIL add_idle: got valid=%b ready=%b op=%b, required 0 1 0000",
                     out_valid, instr_ready, alu_op);
        end
    endtask

    task automatic test_rtype_decode();
        logic [5:0] functs [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                    6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};
        logic [3:0] ops    [11] = '{4'b0001, 4'b1010, 4'b0010, 4'b1011, 4'b0011, 4'b0100,
                                    4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001};
        for (int i = 0; i < 11; i++) begin
            logic [4:0] rd;
            rd = 5'(i + 3);
            accept({6'h00, 5'd1, 5'd2, rd, 5'd0, functs[i]});
            vectors++;
            if (alu_op !== ops[i]) begin
                miscompares++;
                $display("FAIL rtype_op[%0h]: got %b required %b", functs[i], alu_op, ops[i]);
            end
            alu_result = 32'h100 + 32'(i);
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_wen !== 1'b1 || out_dest !== rd ||
                out_result !== 32'h100 + 32'(i)) begin
                miscompares++;
                $display("FAIL rtype_done[%0h]: got valid=%b wen=%b dest=%0d res=%h, required 1 1 %0d %h",
                         functs[i], out_valid, out_wen, out_dest, out_result, rd, 32'h100 + 32'(i));
            end
            drain();
        end
    endtask

    task automatic test_branches();
        logic [31:0] words [8] = '{32'h15090003, 32'h15090003, 32'h11090003, 32'h11090003,
                                   32'h1D000003, 32'h1D000003, 32'h04210003, 32'h04210003};
        logic [31:0] res   [8] = '{32'd4, 32'd0, 32'd0, 32'd5, 32'd5, 32'd0, 32'd9, 32'd0};
        logic        zf    [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0]  ops   [8] = '{4'b1110, 4'b1110, 4'b0010, 4'b0010,
                                   4'b1100, 4'b1100, 4'b1101, 4'b1101};
        logic        taken [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            accept(words[i]);
            vectors++;
            if (alu_op !== ops[i]) begin
                miscompares++;
                $display("FAIL branch_op[%0d]: got %b required %b", i, alu_op, ops[i]);
            end
            alu_result = res[i];
            alu_zero   = zf[i];
            step();
            alu_zero   = 1'b0;
            vectors++;
            if (out_valid !== 1'b1 || out_branch !== taken[i] || out_wen !== 1'b0) begin
                miscompares++;
                $display("FAIL branch_done[%0d]: got valid=%b br=%b wen=%b, required 1 %b 0",
                         i, out_valid, out_branch, out_wen, taken[i]);
            end
            drain();
        end
    endtask

    task automatic test_back_to_back();
        accept(32'h00053100);   // SLL rd=6, rt=5, shamt=4
        vectors++;
        if (alu_op !== 4'b0111 || alu_shamt !== 5'd4 || rt_addr !== 5'd5) begin
            miscompares++;
            $display("FAIL sll_issue: got op=%b shamt=%0d rt=%0d, required 0111 4 5",
                     alu_op, alu_shamt, rt_addr);
        end
        alu_result = 32'h50;
        step();
        // ADDU rd=3, rs=1, rt=2 waits while the consumer stalls
        instr_valid = 1'b1;
        instr       = 32'h00221821;
        alu_result  = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_result !== 32'h50 || out_dest !== 5'd6 ||
                out_wen !== 1'b1 || instr_ready !== 1'b0 || alu_op !== 4'b0000) begin
                miscompares++;
                $display("FAIL sll_stall[%0d]: got valid=%b res=%h dest=%0d wen=%b ready=%b op=%b, required 1 50 6 1 0 0000",
                         i, out_valid, out_result, out_dest, out_wen, instr_ready, alu_op);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready: got %b required 1", instr_ready);
        end
        step();
        instr_valid = 1'b0;
        out_ready   = 1'b0;
        vectors++;
        if (alu_op !== 4'b1010 || out_valid !== 1'b0 || rs_addr !== 5'd1 || rt_addr !== 5'd2) begin
            miscompares++;
            $display("FAIL addu_issue: got op=%b valid=%b rs=%0d rt=%0d, required 1010 0 1 2",
                     alu_op, out_valid, rs_addr, rt_addr);
        end
        alu_result = 32'd3;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'd3 || out_dest !== 5'd3 || out_wen !== 1'b1) begin
            miscompares++;
            $display("FAIL addu_done: got valid=%b res=%h dest=%0d wen=%b, required 1 3 3 1",
                     out_valid, out_result, out_dest, out_wen);
        end
        drain();
    endtask

    task automatic test_lui();
        accept(32'h3C0B1234);
        vectors++;
        if (alu_op !== 4'b1111 || rt_addr !== 5'd11) begin
            miscompares++;
            $display("FAIL lui_issue: got op=%b rt=%0d, required 1111 11", alu_op, rt_addr);
        end
        alu_result = 32'h12340000;
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_dest !== 5'd11 || out_wen !== 1'b1 ||
            out_result !== 32'h12340000 || out_branch !== 1'b0) begin
            miscompares++;
            $display("FAIL lui_done: got valid=%b dest=%0d wen=%b res=%h br=%b, required 1 11 1 12340000 0",
                     out_valid, out_dest, out_wen, out_result, out_branch);
        end
        drain();
    endtask

    task automatic test_reset_in_issue();
        accept(32'h012A4020);
        reset      = 1'b1;
        alu_result = 32'd7;
        step();
        reset = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || alu_op !== 4'b0000 || instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_issue: got valid=%b op=%b ready=%b, required 0 0000 1",
                     out_valid, alu_op, instr_ready);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0 || instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_issue_after: got valid=%b ready=%b, required 0 1", out_valid, instr_ready);
        end
    endtask

    task automatic test_unsupported();
        logic [31:0] words [2] = '{32'hFC000000, 32'h04200000};
        for (int i = 0; i < 2; i++) begin
            accept(words[i]);
            vectors++;
            if (alu_op !== 4'b0000) begin
                miscompares++;
                $display("FAIL unsup_op[%0d]: got %b required 0000", i, alu_op);
            end
            alu_result = 32'h55;
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_wen !== 1'b0 || out_branch !== 1'b0) begin
                miscompares++;
                $display("FAIL unsup_done[%0d]: got valid=%b wen=%b br=%b, required 1 0 0",
                         i, out_valid, out_wen, out_branch);
            end
`ifdef ALU_SEQ_TRAP_EN
            vectors++;
            if (illegal !== 1'b1) begin
                miscompares++;
                $display("FAIL unsup_illegal[%0d]: got %b required 1", i, illegal);
            end
`endif
            drain();
`ifdef ALU_SEQ_TRAP_EN
            vectors++;
            if (illegal !== 1'b0) begin
                miscompares++;
                $display("FAIL unsup_illegal_clear[%0d]: got %b required 0", i, illegal);
            end
`endif
        end
`ifdef ALU_SEQ_TRAP_EN
        // A legal operation must not raise the flag
        accept(32'h3C0B1234);
        alu_result = 32'h12340000;
        step();
        vectors++;
        if (illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL legal_no_illegal: got %b required 0", illegal);
        end
        drain();
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        alu_result  = 32'd0;
        alu_zero    = 1'b0;
        out_ready   = 1'b0;

        test_reset();
        test_add();
        test_rtype_decode();
        test_branches();
        test_back_to_back();
        test_lui();
        test_reset_in_issue();
        test_unsupported();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
